// File: rtl/gpu_pkg.sv
// Shared types for the GPU command loader: instruction word layout, loader FSM
// states and the byte-insertion helper used by the byte assembler.
package gpu_pkg;

  localparam int INST_W   = 82;
  localparam int IDX_W    = 4;

  // Instruction word, MSB first (bits 81..0).
  typedef struct packed {
    logic [3:0]  alpha;
    logic [1:0]  texture;
    logic [23:0] color;
    logic        fill_type;
    logic        layer_num;
    logic [7:0]  y2;
    logic [7:0]  x2;
    logic [7:0]  y1;
    logic [7:0]  x1;
    logic [7:0]  y0;
    logic [7:0]  x0;
    logic        vertice_num;
    logic        inst_type;
  } gpu_inst_t;

  typedef enum logic [1:0] {
    COLLECT    = 2'd0,
    PUSH       = 2'd1,
    WAIT_SPACE = 2'd2
  } cmd_ld_state_t;

  // Place little-endian byte idx into the word; byte 10 carries only bits [1:0],
  // any index past 10 (checksum byte) leaves the word untouched.
  function automatic logic [INST_W-1:0] insert_byte(input logic [INST_W-1:0] word,
                                                    input logic [IDX_W-1:0]  idx,
                                                    input logic [7:0]        b);
    logic [INST_W-1:0] res;
    res = word;
    for (int k = 0; k < 10; k++) begin
      if (idx == IDX_W'(k)) begin
        res[8*k +: 8] = b;
      end
    end
    if (idx == 4'd10) begin
      res[81:80] = b[1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/cmd_ring_buffer.sv
// DEPTH-entry ring buffer of instruction words with show-ahead head output.
// Same-cycle push and pop keeps count steady; a pop on empty is ignored and
// a push on full is accepted only when a pop frees the slot in that cycle.
module cmd_ring_buffer #(
  parameter int DEPTH  = 8,
  parameter int INST_W = 82
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       i_push,
  input  logic [INST_W-1:0]          i_push_data,
  input  logic                       i_pop,
  output logic [INST_W-1:0]          o_head_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [INST_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              w_pop_ok;
  logic              w_push_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign o_count   = r_count;
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_head_data = o_empty ? '0 : r_mem[r_head];

  // Storage write at the tail slot; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_tail] <= i_push_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gpu_cmd_loader.sv
// Host byte-stream to GPU instruction FIFO loader. Assembles 82-bit words from
// little-endian bytes, then pushes them into cmd_ring_buffer.
// Build option GPU_CMD_CHECKSUM_EN: a 12th byte carries the XOR of bytes 0..10;
// a mismatching word is dropped and cksum_err pulses for one cycle.
module gpu_cmd_loader
  import gpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [7:0]                 host_byte,
  input  logic                       host_valid,
  output logic                       host_ready,
  input  logic                       host_abort,
  input  logic                       fifo_read,
  output logic [INST_W-1:0]          fifo_data,
  output logic                       fifo_empty,
  output logic                       fifo_full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       cksum_err
);

`ifdef GPU_CMD_CHECKSUM_EN
  localparam logic [IDX_W-1:0] LAST_IDX = 4'd11;
`else
  localparam logic [IDX_W-1:0] LAST_IDX = 4'd10;
`endif

  cmd_ld_state_t      r_state;
  cmd_ld_state_t      w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [INST_W-1:0]  r_word;
  logic               r_cksum_err;
  logic               w_cksum_ok;
  logic               w_cksum_bad;
  logic               w_byte_we;
  logic               w_push;
  logic               w_ready;
  logic               w_space;
  logic               w_full;
  gpu_inst_t          w_inst;

  assign w_inst     = gpu_inst_t'(r_word);
  assign host_ready = w_ready;
  assign fifo_full  = w_full;
  assign cksum_err  = r_cksum_err;
  // When full, a pop in this cycle frees the slot the push lands in.
  assign w_space    = !w_full || fifo_read;

`ifdef GPU_CMD_CHECKSUM_EN
  logic [7:0] r_xor;

  assign w_cksum_ok = (r_xor == host_byte);

  // Running XOR of payload bytes 0..10 for the trailing checksum compare.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_xor <= 8'h00;
    end else if (w_byte_we && (r_idx != LAST_IDX)) begin
      r_xor <= (r_idx == 4'd0) ? host_byte : (r_xor ^ host_byte);
    end else begin
      r_xor <= r_xor;
    end
  end
`else
  assign w_cksum_ok = 1'b1;
`endif

  // Next-state, byte index and handshake decode for the loader FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_push      = 1'b0;
    w_ready     = 1'b0;
    w_byte_we   = 1'b0;
    w_cksum_bad = 1'b0;
    case (r_state)
      COLLECT: begin
        w_ready = 1'b1;
        if (host_abort) begin
          // Abort wins over a byte in the same cycle, including the last one.
          w_idx_nxt = '0;
        end else if (host_valid) begin
          w_byte_we = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt = '0;
            if (w_cksum_ok) begin
              w_state_nxt = PUSH;
            end else begin
              w_cksum_bad = 1'b1;
            end
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end else begin
          w_idx_nxt = r_idx;
        end
      end
      PUSH, WAIT_SPACE: begin
        if (w_space) begin
          w_push      = 1'b1;
          w_state_nxt = COLLECT;
        end else begin
          w_state_nxt = WAIT_SPACE;
        end
      end
      default: begin
        w_state_nxt = COLLECT;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // FSM state, byte index, word assembly and checksum-error pulse registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= COLLECT;
      r_idx       <= '0;
      r_word      <= '0;
      r_cksum_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cksum_err <= w_cksum_bad;
      if (w_byte_we) begin
        r_word <= insert_byte(r_word, r_idx, host_byte);
      end else begin
        r_word <= r_word;
      end
    end
  end

  cmd_ring_buffer #(
    .DEPTH  (DEPTH),
    .INST_W (INST_W)
  ) u_ring (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_push      (w_push),
    .i_push_data (w_inst),
    .i_pop       (fifo_read),
    .o_head_data (fifo_data),
    .o_empty     (fifo_empty),
    .o_full      (w_full),
    .o_count     (count)
  );

endmodule

// File: tb/tb_gpu_cmd_loader.sv
// Directed self-checking bench for gpu_cmd_loader (DEPTH=8). Handles both the
// default 11-byte framing and the GPU_CMD_CHECKSUM_EN 12-byte framing.
module tb_gpu_cmd_loader;
  import gpu_pkg::*;

  localparam int DEPTH = 8;
`ifdef GPU_CMD_CHECKSUM_EN
  localparam int NB = 12;
`else
  localparam int NB = 11;
`endif

  logic              clk = 1'b0;
  logic              n_rst;
  logic [7:0]        host_byte;
  logic              host_valid;
  logic              host_ready;
  logic              host_abort;
  logic              fifo_read;
  logic [INST_W-1:0] fifo_data;
  logic              fifo_empty;
  logic              fifo_full;
  logic [3:0]        count;
  logic              cksum_err;

  int checks = 0;
  int errors = 0;

  logic [INST_W-1:0] w1;

  gpu_cmd_loader #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .host_byte  (host_byte),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_abort (host_abort),
    .fifo_read  (fifo_read),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .count      (count),
    .cksum_err  (cksum_err)
  );

  always #5 clk = ~clk;

  // Distinct test word number i.
  function automatic logic [INST_W-1:0] mk(input int i);
    mk = {4'hA, 2'h1, 24'h123400 | 24'(i), 1'b1, 1'b0,
          8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3), 8'(i + 4), 8'(i + 5), 1'b0, 1'b1};
  endfunction

  // Byte k of the host stream for word w (k==11 is the checksum byte).
  function automatic logic [7:0] byte_of(input logic [INST_W-1:0] w, input int k);
    logic [7:0] x;
    if (k < 10) begin
      byte_of = w[8*k +: 8];
    end else if (k == 10) begin
      byte_of = {6'b0, w[81:80]};
    end else begin
      x = {6'b0, w[81:80]};
      for (int j = 0; j < 10; j++) x = x ^ w[8*j +: 8];
      byte_of = x;
    end
  endfunction

  // Offer one byte (optionally with abort) and hold it until the accepting edge.
  task automatic send_byte(input logic [7:0] b, input logic ab);
    int t;
    t = 0;
    host_byte  = b;
    host_valid = 1'b1;
    host_abort = ab;
    while (!host_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!host_ready) begin
      errors++;
      $display("FAIL send_timeout: host_ready=%0b required 1", host_ready);
    end
    checks++;
    @(posedge clk); #1;
    host_valid = 1'b0;
    host_abort = 1'b0;
  endtask

  // Send the first n bytes of w; abort rides along with the last one if ab_last.
  task automatic send_bytes(input logic [INST_W-1:0] w, input int n, input logic ab_last);
    for (int k = 0; k < n; k++) send_byte(byte_of(w, k), ab_last && (k == n - 1));
  endtask

  task automatic pop_one();
    fifo_read = 1'b1;
    @(posedge clk); #1;
    fifo_read = 1'b0;
  endtask

  task automatic test_reset();
    send_bytes(mk(20), NB, 1'b0);
    @(posedge clk); #1;
    send_bytes(mk(21), 3, 1'b0);
    n_rst = 1'b0;
    #2;
    checks++;
    if (host_ready !== 1'b1 || fifo_empty !== 1'b1 || fifo_full !== 1'b0 ||
        count !== 4'd0 || fifo_data !== '0 || cksum_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%0b empty=%0b full=%0b count=%0d data=%h err=%0b required 1 1 0 0 0 0",
               host_ready, fifo_empty, fifo_full, count, fifo_data, cksum_err);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_word();
    send_bytes(w1, NB, 1'b0);
    checks++;
    if (fifo_empty !== 1'b1 || host_ready !== 1'b0) begin
      errors++;
      $display("FAIL latency_edgeN: empty=%0b ready=%0b required 1 0", fifo_empty, host_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (fifo_empty !== 1'b0 || fifo_data !== w1 || count !== 4'd1 || host_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_word: empty=%0b data=%h count=%0d ready=%0b required 0 %h 1 1",
               fifo_empty, fifo_data, count, host_ready, w1);
    end
    pop_one();
    checks++;
    if (fifo_empty !== 1'b1 || count !== 4'd0 || fifo_data !== '0) begin
      errors++;
      $display("FAIL single_pop: empty=%0b count=%0d data=%h required 1 0 0", fifo_empty, count, fifo_data);
    end
  endtask

  task automatic test_full_wait();
    for (int i = 0; i < DEPTH; i++) send_bytes(mk(i), NB, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (fifo_full !== 1'b1 || count !== 4'd8 || fifo_data !== mk(0)) begin
      errors++;
      $display("FAIL fill: full=%0b count=%0d data=%h required 1 8 %h", fifo_full, count, fifo_data, mk(0));
    end
    send_bytes(mk(8), NB, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (host_ready !== 1'b0 || count !== 4'd8) begin
      errors++;
      $display("FAIL wait_space: ready=%0b count=%0d required 0 8", host_ready, count);
    end
    pop_one();
    checks++;
    if (count !== 4'd8 || host_ready !== 1'b1 || fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL push_on_pop_full: count=%0d ready=%0b full=%0b required 8 1 1", count, host_ready, fifo_full);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++;
      if (fifo_data !== mk(i)) begin
        errors++;
        $display("FAIL drain_order[%0d]: data=%h required %h", i, fifo_data, mk(i));
      end
      pop_one();
    end
    checks++;
    if (fifo_empty !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL drain_end: empty=%0b count=%0d required 1 0", fifo_empty, count);
    end
  endtask

  task automatic test_read_empty();
    fifo_read = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    fifo_read = 1'b0;
    checks++;
    if (count !== 4'd0 || fifo_empty !== 1'b1 || fifo_data !== '0) begin
      errors++;
      $display("FAIL read_empty: count=%0d empty=%0b data=%h required 0 1 0", count, fifo_empty, fifo_data);
    end
    send_bytes(mk(30), NB, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (fifo_data !== mk(30) || count !== 4'd1) begin
      errors++;
      $display("FAIL read_empty_after: data=%h count=%0d required %h 1", fifo_data, count, mk(30));
    end
    pop_one();
  endtask

  task automatic test_abort();
    send_bytes(mk(40), 5, 1'b0);
    host_abort = 1'b1;
    @(posedge clk); #1;
    host_abort = 1'b0;
    send_bytes(mk(41), NB, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (count !== 4'd1 || fifo_data !== mk(41)) begin
      errors++;
      $display("FAIL abort_mid: count=%0d data=%h required 1 %h", count, fifo_data, mk(41));
    end
    pop_one();
    // Abort together with the final byte: nothing is pushed.
    send_bytes(mk(42), NB, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (count !== 4'd0 || host_ready !== 1'b1 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL abort_last: count=%0d ready=%0b empty=%0b required 0 1 1", count, host_ready, fifo_empty);
    end
    send_bytes(mk(43), NB, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (count !== 4'd1 || fifo_data !== mk(43)) begin
      errors++;
      $display("FAIL abort_last_next: count=%0d data=%h required 1 %h", count, fifo_data, mk(43));
    end
    pop_one();
  endtask

`ifdef GPU_CMD_CHECKSUM_EN
  task automatic test_checksum();
    send_bytes(mk(50), 11, 1'b0);
    send_byte(byte_of(mk(50), 11) ^ 8'h01, 1'b0);
    checks++;
    if (cksum_err !== 1'b1) begin
      errors++;
      $display("FAIL cksum_pulse: cksum_err=%0b required 1", cksum_err);
    end
    @(posedge clk); #1;
    checks++;
    if (cksum_err !== 1'b0 || count !== 4'd0 || host_ready !== 1'b1) begin
      errors++;
      $display("FAIL cksum_drop: err=%0b count=%0d ready=%0b required 0 0 1", cksum_err, count, host_ready);
    end
    send_bytes(mk(51), NB, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (count !== 4'd1 || fifo_data !== mk(51) || cksum_err !== 1'b0) begin
      errors++;
      $display("FAIL cksum_good: count=%0d data=%h err=%0b required 1 %h 0", count, fifo_data, cksum_err, mk(51));
    end
    pop_one();
  endtask
`endif

  initial begin
    w1 = {4'h0, 2'h0, 24'hFFEEDD, 1'b0, 1'b0, 8'd10, 8'd50, 8'd60, 8'd10, 8'd10, 8'd10, 1'b1, 1'b0};
    n_rst      = 1'b0;
    host_byte  = 8'h00;
    host_valid = 1'b0;
    host_abort = 1'b0;
    fifo_read  = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (host_ready !== 1'b1 || fifo_empty !== 1'b1 || count !== 4'd0 || fifo_data !== '0) begin
      errors++;
      $display("FAIL power_on_reset: ready=%0b empty=%0b count=%0d data=%h required 1 1 0 0",
               host_ready, fifo_empty, count, fifo_data);
    end
    n_rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single_word();
    test_full_wait();
    test_read_empty();
    test_abort();
`ifdef GPU_CMD_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
